// File: rtl/incadd_rr_arbiter.sv
// Purpose: N_REQ requesters share one (a + b + 1) adder; round-robin grant, registered result tagged with winner ID.
// Latency: 1 cycle from accept (req_valid & req_ready) to res_valid.
// Backpressure: while res_valid && !res_ready, no grants are issued and all outputs hold.
//
// Ports:
//   clk, rst             single clock, synchronous active-high reset
//   req_valid/req_ready  per-requester handshake; req_ready is one-hot (the grant) or zero
//   req_a/req_b          packed operands, requester i at [i*WIDTH +: WIDTH]
//   res_valid/res_ready  result handshake
//   res_data/res_carry   low WIDTH bits and carry-out of a + b + 1
//   res_id               index of the requester that produced the result
module incadd_rr_arbiter #(
    parameter int N_REQ = 4,
    parameter int WIDTH = 8,
    localparam int IDW  = $clog2(N_REQ)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [N_REQ-1:0]       req_valid,
    output logic [N_REQ-1:0]       req_ready,
    input  logic [N_REQ*WIDTH-1:0] req_a,
    input  logic [N_REQ*WIDTH-1:0] req_b,
    output logic                   res_valid,
    input  logic                   res_ready,
    output logic [WIDTH-1:0]       res_data,
    output logic                   res_carry,
    output logic [IDW-1:0]         res_id
);

    logic [IDW-1:0]   rr_ptr;
    logic             accept_en;
    logic             grant_found;
    logic [IDW-1:0]   grant_idx;
    logic             accept;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic [WIDTH:0]   sum;
    logic [IDW-1:0]   ptr_next;

    // Slot can take a new result if it is empty or being drained this cycle.
    assign accept_en = !res_valid || res_ready;

    // Search from rr_ptr upward, wrapping; the first valid requester wins.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        for (int k = 0; k < N_REQ; k++) begin
            if (!grant_found) begin
                if (req_valid[(int'(rr_ptr) + k) % N_REQ]) begin
                    grant_found = 1'b1;
                    grant_idx   = IDW'((int'(rr_ptr) + k) % N_REQ);
                end
            end
        end
    end

    // Ready is the grant itself; gated off during reset and while the slot is blocked.
    assign accept = grant_found && accept_en && !rst;

    always_comb begin
        req_ready = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (accept && (grant_idx == IDW'(i))) begin
                req_ready[i] = 1'b1;
            end
        end
    end

    assign op_a = req_a[grant_idx*WIDTH +: WIDTH];
    assign op_b = req_b[grant_idx*WIDTH +: WIDTH];
    assign sum  = {1'b0, op_a} + {1'b0, op_b} + {{WIDTH{1'b0}}, 1'b1};

    // Explicit wrap so non-power-of-two N_REQ stays in range.
    assign ptr_next = (grant_idx == IDW'(N_REQ - 1)) ? '0 : grant_idx + 1'b1;

    always_ff @(posedge clk) begin
        if (rst) begin
            res_valid <= 1'b0;
            res_data  <= '0;
            res_carry <= 1'b0;
            res_id    <= '0;
            rr_ptr    <= '0;
        end else if (accept) begin
            // Also covers drain-and-refill in the same cycle: slot stays full.
            res_valid <= 1'b1;
            res_data  <= sum[WIDTH-1:0];
            res_carry <= sum[WIDTH];
            res_id    <= grant_idx;
            rr_ptr    <= ptr_next;
        end else if (res_ready) begin
            // Drain only; payload keeps its last value.
            res_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_incadd_rr_arbiter.sv
module tb_incadd_rr_arbiter;

    localparam int N = 4;
    localparam int W = 8;

    logic             clk = 1'b0;
    logic             rst;
    logic [N-1:0]     req_valid;
    logic [N-1:0]     req_ready;
    logic [N*W-1:0]   req_a;
    logic [N*W-1:0]   req_b;
    logic             res_valid;
    logic             res_ready;
    logic [W-1:0]     res_data;
    logic             res_carry;
    logic [1:0]       res_id;

    int checks = 0;
    int passes = 0;

    // Reference model state
    int m_vld, m_data, m_carry, m_id, m_ptr;

    incadd_rr_arbiter #(.N_REQ(N), .WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_data  (res_data),
        .res_carry (res_carry),
        .res_id    (res_id)
    );

    always #5 clk = ~clk;

    // Requester the model would grant with the current inputs, or -1.
    function automatic int model_grant();
        if (rst) return -1;
        if (m_vld != 0 && !res_ready) return -1;
        for (int k = 0; k < N; k++) begin
            if (req_valid[(m_ptr + k) % N]) return (m_ptr + k) % N;
        end
        return -1;
    endfunction

    function automatic logic [N-1:0] model_ready();
        int g;
        g = model_grant();
        return (g >= 0) ? (N'(1) << g) : '0;
    endfunction

    // Advance one clock and update the model from the inputs seen at the edge.
    task automatic tick();
        int g, a, b, s;
        g = model_grant();
        a = 0;
        b = 0;
        if (g >= 0) begin
            a = int'(req_a[g*W +: W]);
            b = int'(req_b[g*W +: W]);
        end
        @(posedge clk);
        if (rst) begin
            m_vld = 0; m_data = 0; m_carry = 0; m_id = 0; m_ptr = 0;
        end else if (g >= 0) begin
            s       = a + b + 1;
            m_data  = s % 256;
            m_carry = s / 256;
            m_id    = g;
            m_vld   = 1;
            m_ptr   = (g + 1) % N;
        end else if (res_ready) begin
            m_vld = 0;
        end
        #1;
    endtask

    task automatic do_reset();
        rst       = 1'b1;
        req_valid = '0;
        res_ready = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst       = 1'b1;
        req_valid = 4'hF;
        req_a     = $urandom;
        req_b     = $urandom;
        res_ready = 1'b1;
        #1;
        checks++; if (req_ready !== 4'b0000) $display("FAIL reset_ready got=%b exp=0000", req_ready); else passes++;
        tick();
        tick();
        checks++; if (res_valid !== 1'b0) $display("FAIL reset_valid got=%b exp=0", res_valid); else passes++;
        checks++; if (res_data !== 8'h00) $display("FAIL reset_data got=%h exp=00", res_data); else passes++;
        checks++; if (res_carry !== 1'b0) $display("FAIL reset_carry got=%b exp=0", res_carry); else passes++;
        checks++; if (res_id !== 2'd0) $display("FAIL reset_id got=%0d exp=0", res_id); else passes++;
        rst = 1'b0;
    endtask

    task automatic test_basic();
        do_reset();
        req_valid     = 4'b0001;
        req_a         = $urandom;
        req_b         = $urandom;
        req_a[0 +: W] = 8'h10;
        req_b[0 +: W] = 8'h20;
        res_ready     = 1'b1;
        #1;
        checks++; if (req_ready !== 4'b0001) $display("FAIL basic_ready got=%b exp=0001", req_ready); else passes++;
        tick();
        req_valid = '0;
        checks++; if (res_valid !== 1'b1) $display("FAIL basic_valid got=%b exp=1", res_valid); else passes++;
        checks++; if (res_data !== 8'h31) $display("FAIL basic_data got=%h exp=31", res_data); else passes++;
        checks++; if (res_carry !== 1'b0) $display("FAIL basic_carry got=%b exp=0", res_carry); else passes++;
        checks++; if (res_id !== 2'd0) $display("FAIL basic_id got=%0d exp=0", res_id); else passes++;
    endtask

    task automatic test_wrap();
        logic [7:0] ta [3] = '{8'hFF, 8'hFF, 8'h7F};
        logic [7:0] tb [3] = '{8'h00, 8'hFF, 8'h7F};
        logic [7:0] td [3] = '{8'h00, 8'hFF, 8'hFF};
        logic       tc [3] = '{1'b1, 1'b1, 1'b0};
        for (int t = 0; t < 3; t++) begin
            req_valid     = 4'b0100;
            req_a         = $urandom;
            req_b         = $urandom;
            req_a[2*W +: W] = ta[t];
            req_b[2*W +: W] = tb[t];
            res_ready     = 1'b1;
            tick();
            checks++; if (res_data !== td[t]) $display("FAIL wrap_data[%0d] got=%h exp=%h", t, res_data, td[t]); else passes++;
            checks++; if (res_carry !== tc[t]) $display("FAIL wrap_carry[%0d] got=%b exp=%b", t, res_carry, tc[t]); else passes++;
            checks++; if (res_id !== 2'd2) $display("FAIL wrap_id[%0d] got=%0d exp=2", t, res_id); else passes++;
        end
        req_valid = '0;
    endtask

    task automatic test_rr_sequence();
        do_reset();
        req_valid = 4'hF;
        res_ready = 1'b1;
        for (int k = 0; k < 6; k++) begin
            req_a = $urandom;
            req_b = $urandom;
            #1;
            checks++; if (req_ready !== (4'b0001 << (k % 4))) $display("FAIL rr_ready[%0d] got=%b exp=%b", k, req_ready, 4'b0001 << (k % 4)); else passes++;
            tick();
            checks++; if (res_id !== 2'(k % 4)) $display("FAIL rr_id[%0d] got=%0d exp=%0d", k, res_id, k % 4); else passes++;
            checks++; if (res_valid !== 1'b1) $display("FAIL rr_valid[%0d] got=%b exp=1", k, res_valid); else passes++;
            checks++; if (res_data !== 8'(m_data)) $display("FAIL rr_data[%0d] got=%h exp=%h", k, res_data, 8'(m_data)); else passes++;
        end
    endtask

    // Runs right after test_rr_sequence: slot full, next in line is requester 2.
    task automatic test_backpressure();
        logic [7:0] held_data;
        logic [1:0] held_id;
        held_data = 8'(m_data);
        held_id   = 2'(m_id);
        res_ready = 1'b0;
        req_valid = 4'hF;
        for (int k = 0; k < 3; k++) begin
            req_a = $urandom;
            req_b = $urandom;
            #1;
            checks++; if (req_ready !== 4'b0000) $display("FAIL bp_ready[%0d] got=%b exp=0000", k, req_ready); else passes++;
            tick();
            checks++; if (res_valid !== 1'b1) $display("FAIL bp_valid[%0d] got=%b exp=1", k, res_valid); else passes++;
            checks++; if (res_data !== held_data) $display("FAIL bp_data[%0d] got=%h exp=%h", k, res_data, held_data); else passes++;
            checks++; if (res_id !== held_id) $display("FAIL bp_id[%0d] got=%0d exp=%0d", k, res_id, held_id); else passes++;
        end
        res_ready = 1'b1;
        #1;
        checks++; if (req_ready !== 4'b0100) $display("FAIL bp_release_ready got=%b exp=0100", req_ready); else passes++;
        tick();
        checks++; if (res_id !== 2'd2) $display("FAIL bp_release_id got=%0d exp=2", res_id); else passes++;
        checks++; if (res_data !== 8'(m_data)) $display("FAIL bp_release_data got=%h exp=%h", res_data, 8'(m_data)); else passes++;
    endtask

    task automatic test_ptr_wrap();
        do_reset();
        req_a     = $urandom;
        req_b     = $urandom;
        req_valid = 4'b0010;
        res_ready = 1'b1;
        tick();
        req_valid = 4'b0001;
        #1;
        checks++; if (req_ready !== 4'b0001) $display("FAIL ptrwrap_ready got=%b exp=0001", req_ready); else passes++;
        tick();
        checks++; if (res_id !== 2'd0) $display("FAIL ptrwrap_id got=%0d exp=0", res_id); else passes++;
        req_valid = 4'hF;
        #1;
        checks++; if (req_ready !== 4'b0010) $display("FAIL ptrwrap_next got=%b exp=0010", req_ready); else passes++;
        tick();
    endtask

    task automatic test_reset_mid();
        req_valid = '0;
        res_ready = 1'b0;
        checks++; if (res_valid !== 1'b1) $display("FAIL rstmid_pre_valid got=%b exp=1", res_valid); else passes++;
        rst       = 1'b1;
        req_valid = 4'hF;
        #1;
        checks++; if (req_ready !== 4'b0000) $display("FAIL rstmid_ready got=%b exp=0000", req_ready); else passes++;
        tick();
        rst = 1'b0;
        checks++; if (res_valid !== 1'b0) $display("FAIL rstmid_valid got=%b exp=0", res_valid); else passes++;
        checks++; if (res_id !== 2'd0) $display("FAIL rstmid_id got=%0d exp=0", res_id); else passes++;
        req_valid = 4'b1001;
        res_ready = 1'b1;
        #1;
        checks++; if (req_ready !== 4'b0001) $display("FAIL rstmid_first got=%b exp=0001", req_ready); else passes++;
        tick();
        checks++; if (res_id !== 2'd0) $display("FAIL rstmid_first_id got=%0d exp=0", res_id); else passes++;
        #1;
        checks++; if (req_ready !== 4'b1000) $display("FAIL rstmid_second got=%b exp=1000", req_ready); else passes++;
        tick();
        req_valid = '0;
    endtask

    task automatic test_random();
        for (int k = 0; k < 400; k++) begin
            rst       = ($urandom_range(0, 49) == 0);
            req_valid = N'($urandom);
            req_a     = $urandom;
            req_b     = $urandom;
            res_ready = ($urandom_range(0, 3) != 0);
            #1;
            checks++; if (req_ready !== model_ready()) $display("FAIL rand_ready[%0d] got=%b exp=%b", k, req_ready, model_ready()); else passes++;
            tick();
            checks++; if (res_valid !== 1'(m_vld)) $display("FAIL rand_valid[%0d] got=%b exp=%0d", k, res_valid, m_vld); else passes++;
            checks++; if (res_data !== 8'(m_data)) $display("FAIL rand_data[%0d] got=%h exp=%h", k, res_data, 8'(m_data)); else passes++;
            checks++; if (res_carry !== 1'(m_carry)) $display("FAIL rand_carry[%0d] got=%b exp=%0d", k, res_carry, m_carry); else passes++;
            checks++; if (res_id !== 2'(m_id)) $display("FAIL rand_id[%0d] got=%0d exp=%0d", k, res_id, m_id); else passes++;
        end
        rst = 1'b0;
    endtask

    initial begin
        m_vld = 0; m_data = 0; m_carry = 0; m_id = 0; m_ptr = 0;
        rst       = 1'b1;
        req_valid = '0;
        req_a     = '0;
        req_b     = '0;
        res_ready = 1'b0;
        @(posedge clk);
        #1;
        test_reset();
        test_basic();
        test_wrap();
        test_rr_sequence();
        test_backpressure();
        test_ptr_wrap();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
